// File: rtl/mem_disp_scan.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | mem_disp_scan: walks the 1-bit display memory and holds each bit on LED |
// | Rev 1.0                                                                 |
// +------------------------------------------------------------------------+
module mem_disp_scan #(
  parameter int ADDR_W = 5,
  parameter int HOLD_W = 16,
  parameter int HOLD   = 8
) (
  input  logic              clk,
  input  logic              RSTn,
  input  logic              start,
  input  logic              loop,
  input  logic              abort,
  input  logic [ADDR_W-1:0] len_m1,
  input  logic              rd_d,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              busy,
  output logic              led_o,
  output logic [ADDR_W-1:0] bit_idx,
  output logic              done
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LATCH = 3'd2,
    S_HOLD  = 3'd3,
    S_FIN   = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0]   bit_idx_q, bit_idx_d;
  logic [ADDR_W-1:0]   len_q, len_d;
  logic [HOLD_W-1:0]   cnt_q, cnt_d;
  logic                led_q, led_d;
  logic                loop_q, loop_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    bit_idx_d = bit_idx_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    led_d     = led_q;
    loop_d    = loop_q;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          len_d     = len_m1;
          loop_d    = loop;
          rd_addr_d = '0;
          state_d   = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        // rd_d now carries mem[rd_addr] captured at the FETCH edge
        led_d     = rd_d;
        bit_idx_d = rd_addr_q;
        cnt_d     = '0;
        state_d   = S_HOLD;
      end
      S_HOLD: begin
        cnt_d = cnt_q + HOLD_W'(1);
        if (cnt_q == HOLD_LAST) begin
          if (rd_addr_q != len_q) begin
            rd_addr_d = rd_addr_q + ADDR_W'(1);
            state_d   = S_FETCH;
          end else if (loop_q) begin
            rd_addr_d = '0;
            state_d   = S_FETCH;
          end else begin
            state_d = S_FIN;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (abort && (state_q != S_IDLE)) begin
      state_d   = S_IDLE;
      led_d     = 1'b0;
      rd_addr_d = '0;
      bit_idx_d = '0;
    end
  end

  // Status flags are registered decodes of the next state so they align with state_q.
  always_comb begin
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FIN);
  end

  always_ff @(posedge clk) begin
    if (!RSTn) begin
      state_q   <= S_IDLE;
      rd_addr_q <= '0;
      bit_idx_q <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      led_q     <= 1'b0;
      loop_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      bit_idx_q <= bit_idx_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      led_q     <= led_d;
      loop_q    <= loop_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign rd_addr = rd_addr_q;
  assign bit_idx = bit_idx_q;
  assign led_o   = led_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_disp_scan.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_mem_disp_scan: randomized scoreboard bench for mem_disp_scan         |
// | Rev 1.0                                                                 |
// +------------------------------------------------------------------------+
module tb_mem_disp_scan;

  localparam int AW = 5;
  localparam int HW = 16;
  localparam int H  = 8;
  localparam int P  = H + 2;

  logic          clk = 1'b0;
  logic          RSTn, start, loop, abort, rd_d;
  logic [AW-1:0] len_m1, rd_addr, bit_idx;
  logic          busy, led_o, done;

  mem_disp_scan #(.ADDR_W(AW), .HOLD_W(HW), .HOLD(H)) dut (
    .clk(clk), .RSTn(RSTn), .start(start), .loop(loop), .abort(abort),
    .len_m1(len_m1), .rd_d(rd_d), .rd_addr(rd_addr), .busy(busy),
    .led_o(led_o), .bit_idx(bit_idx), .done(done)
  );

  always #5 clk = ~clk;

  // display memory with a registered read port
  logic mem [0:31];
  always @(posedge clk) rd_d <= mem[rd_addr];

  typedef struct {
    logic          led;
    logic [AW-1:0] idx;
    logic [AW-1:0] addr;
    logic          busy;
    logic          done;
    int            edge_no;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   edge_no  = 0;
  int   exp_dones = 0;
  int   dut_dones = 0;

  // reference model state: scan in progress, edges since start, latched scan setup
  logic          m_active = 1'b0;
  int            m_p = 0;
  int            m_n = 1;
  logic          m_lp = 1'b0;
  logic          m_snap [0:31];
  logic          m_led = 1'b0;
  logic [AW-1:0] m_idx = '0;
  logic [AW-1:0] m_addr = '0;

  // outputs p edges after the start edge, from the bit-period arithmetic
  function automatic exp_t calc(int p);
    exp_t e;
    int j, r, b, pb;
    j = p / P;
    r = p % P;
    e.busy = 1'b1;
    e.done = 1'b0;
    e.edge_no = edge_no;
    if (!m_lp && j >= m_n) begin
      e.led  = m_snap[m_n-1];
      e.idx  = AW'(m_n - 1);
      e.addr = AW'(m_n - 1);
      e.done = 1'b1;
      return e;
    end
    b = j % m_n;
    e.addr = AW'(b);
    if (r >= 2) begin
      e.led = m_snap[b];
      e.idx = AW'(b);
    end else if (j == 0) begin
      e.led = m_led;
      e.idx = m_idx;
    end else begin
      pb = (j - 1) % m_n;
      e.led = m_snap[pb];
      e.idx = AW'(pb);
    end
    return e;
  endfunction

  task automatic model_step();
    exp_t e;
    edge_no++;
    e.edge_no = edge_no;
    e.busy = 1'b0;
    e.done = 1'b0;
    if (!RSTn) begin
      m_active = 1'b0;
      m_led = 1'b0; m_idx = '0; m_addr = '0;
    end else if (m_active) begin
      m_p++;
      if (abort) begin
        m_active = 1'b0;
        m_led = 1'b0; m_idx = '0; m_addr = '0;
      end else if (!m_lp && m_p == m_n * P + 1) begin
        m_active = 1'b0;
        m_led  = m_snap[m_n-1];
        m_idx  = AW'(m_n - 1);
        m_addr = AW'(m_n - 1);
      end else begin
        e = calc(m_p);
      end
    end else if (start && !abort) begin
      m_active = 1'b1;
      m_p  = 0;
      m_n  = int'(len_m1) + 1;
      m_lp = loop;
      m_snap = mem;
      e = calc(0);
    end
    if (!e.busy) begin
      e.led = m_led; e.idx = m_idx; e.addr = m_addr;
    end
    if (e.done) exp_dones++;
    q.push_back(e);
  endtask

  // monitor: every cycle is a display output; compare away from the active edge
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) dut_dones++;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_checks++;
      if ({led_o, bit_idx, rd_addr, busy, done} === {e.led, e.idx, e.addr, e.busy, e.done})
        n_pass++;
      else
        $display("FAIL cycle%0d: got led=%b idx=%0d addr=%0d busy=%b done=%b, want led=%b idx=%0d addr=%0d busy=%b done=%b",
                 e.edge_no, led_o, bit_idx, rd_addr, busy, done,
                 e.led, e.idx, e.addr, e.busy, e.done);
    end
  end

  task automatic cyc(input logic s, input logic a, input logic rn);
    start = s; abort = a; RSTn = rn;
    @(posedge clk);
    model_step();
    #1;
    start = 1'b0; abort = 1'b0; RSTn = 1'b1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 32; i++) mem[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic load_pat();
    logic [7:0] pat;
    pat = 8'b0100_1101;
    fill_random();
    for (int i = 0; i < 8; i++) mem[i] = pat[i];
    len_m1 = 5'd7;
    loop = 1'b0;
  endtask

  initial begin
    start = 1'b0; abort = 1'b0; loop = 1'b0; len_m1 = '0; RSTn = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 1'b0;
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    run(2);

    // basic 8-bit pattern, single pass
    load_pat();
    cyc(1'b1, 1'b0, 1'b1);
    run(90);

    // single bit
    mem[0] = 1'b1; len_m1 = '0; loop = 1'b0;
    cyc(1'b1, 1'b0, 1'b1);
    run(15);

    // full-depth loop across two passes, wrap 31 -> 0
    fill_random(); mem[31] = 1'b1; mem[0] = 1'b0;
    len_m1 = 5'd31; loop = 1'b1;
    cyc(1'b1, 1'b0, 1'b1);
    run(660);
    cyc(1'b0, 1'b1, 1'b1);
    run(3);

    // abort during HOLD of bit 3, then abort in IDLE (alone and with start)
    load_pat();
    cyc(1'b1, 1'b0, 1'b1);
    run(34);
    cyc(1'b0, 1'b1, 1'b1);
    run(2);
    cyc(1'b1, 1'b1, 1'b1);
    run(2);
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    run(85);

    // start during HOLD and during FIN, setup changes mid-scan
    load_pat();
    cyc(1'b1, 1'b0, 1'b1);
    run(4);
    cyc(1'b1, 1'b0, 1'b1);
    len_m1 = 5'd2; loop = 1'b1;
    run(75);
    cyc(1'b1, 1'b0, 1'b1);
    run(5);

    // reset during bit 5, then a fresh scan
    load_pat();
    cyc(1'b1, 1'b0, 1'b1);
    run(53);
    cyc(1'b0, 1'b0, 1'b0);
    run(3);
    cyc(1'b1, 1'b0, 1'b1);
    run(85);

    // randomized scans with stray start/abort and setup changes
    for (int t = 0; t < 12; t++) begin
      fill_random();
      len_m1 = ($urandom_range(0, 3) == 0) ? 5'(31) : 5'($urandom_range(0, 7));
      loop = 1'($urandom_range(0, 1));
      cyc(1'b1, 1'b0, 1'b1);
      for (int c = 0; c < int'($urandom_range(20, 200)); c++) begin
        cyc(($urandom_range(0, 19) == 0), ($urandom_range(0, 99) == 0), 1'b1);
        if ($urandom_range(0, 29) == 0) begin
          len_m1 = 5'($urandom_range(0, 31));
          loop = 1'($urandom_range(0, 1));
        end
      end
      cyc(1'b0, 1'b1, 1'b1);
      run(3);
    end

    run(2);
    @(negedge clk);
    #1;

    n_checks++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL queue_drain: got %0d pending entries, want 0", q.size());

    n_checks++;
    if (dut_dones == exp_dones) n_pass++;
    else $display("FAIL done_count: got %0d pulses, want %0d", dut_dones, exp_dones);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_disp_scan.md
Name: mem_disp_scan

Overview:
- Read-side controller for the 1-bit x 32 decoded-message display memory.
- On a start request it walks addresses 0..LEN-1 and fetches each decoded bit through the memory's registered (1-cycle) read port.
- Each bit is held on a LED/display output for a programmable number of cycles, then the next bit is fetched. Single-pass and continuous-loop modes are supported.
- Sits between the display memory and the board display logic. While busy, it owns the shared memory address bus.

Parameters:
- ADDR_W, 5, memory address width (depth 2^ADDR_W = 32).
- HOLD_W, 16, width of the hold counter.
- HOLD, 8, cycles each bit is held on led_o; legal range 1..2^HOLD_W-1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- RSTn  input  1  synchronous, active-low reset.
- start  input  1  one-cycle request to begin a scan; sampled only in IDLE.
- loop  input  1  latched at start; 1 = restart at address 0 after the last bit.
- abort  input  1  stop the scan immediately; takes priority over everything except reset.
- len_m1  input  ADDR_W  number of bits to display minus 1; latched at start.
- rd_d  input  1  memory read data; valid the cycle after rd_addr is presented.
- rd_addr  output  ADDR_W  memory address; registered.
- busy  output  1  high in every non-IDLE state; the writer must not drive the address or wr while busy.
- led_o  output  1  displayed decoded bit.
- bit_idx  output  ADDR_W  index of the bit currently shown on led_o.
- done  output  1  one-cycle pulse at the end of a non-loop scan.

Behaviour:
- Reset is synchronous. When RSTn=0 at a clock edge:
  - state=IDLE.
  - rd_addr=0, led_o=0, bit_idx=0, busy=0, done=0.
  - hold counter=0; latched len and loop=0.
- States: IDLE, FETCH, LATCH, HOLD, FIN.
- IDLE:
  - start=1 → latch len_m1 and loop, set rd_addr=0, go FETCH.
  - led_o keeps its previous value.
- FETCH: rd_addr stable. The memory captures mem[rd_addr] at this edge. Go LATCH.
- LATCH: led_o<=rd_d, bit_idx<=rd_addr, counter<=0. Go HOLD.
- HOLD:
  - Counter increments each cycle.
  - When counter==HOLD-1 and rd_addr!=len: rd_addr<=rd_addr+1, go FETCH.
  - When counter==HOLD-1 and rd_addr==len and loop=1: rd_addr<=0, go FETCH.
  - When counter==HOLD-1 and rd_addr==len and loop=0: go FIN.
- FIN: done=1 for exactly this cycle. Go IDLE.
- Timing:
  - start at edge k → led_o shows bit 0 after edge k+2.
  - Each bit period is HOLD+2 cycles; led_o changes only at the LATCH edge, with no intermediate glitch.
  - A non-loop scan of N=len_m1+1 bits takes N*(HOLD+2)+1 cycles from start to the done edge.
- start while busy: ignored, including in FIN.
- len_m1 or loop changes mid-scan: no effect until the next start.
- len_m1=0: a single bit is shown; the address never increments.
- len_m1=31: rd_addr reaches 31. In loop mode it wraps explicitly to 0, not by overflow.
- abort=1 in any non-IDLE state:
  - Next state IDLE; led_o<=0, rd_addr<=0, bit_idx<=0, done stays 0.
  - abort in IDLE has no effect.
  - abort and start in the same IDLE cycle: abort wins and no scan starts.
- Reset mid-scan: same values as the reset list; no done pulse.
- busy is a registered decode of state, high from the edge after start until the edge that enters IDLE.

Test Plan:
- Memory preloaded 0..7 = 1,0,1,1,0,0,1,0; HOLD=8; start, loop=0, len_m1=7 → led_o sequence 1,0,1,1,0,0,1,0, each held 10 cycles, bit_idx 0..7; done pulses once, 81 cycles after start; busy deasserts the cycle after done.
- len_m1=0, mem[0]=1 → led_o=1 for 10 cycles; rd_addr stays 0; single done pulse.
- loop=1, len_m1=31, mem[31]=1, mem[0]=0 → after bit 31, rd_addr wraps to 0 and led_o goes 1→0; done is never asserted across 2 full passes (640 cycles).
- Abort issued in HOLD of bit 3 → next cycle state IDLE, led_o=0, busy=0, no done; a new start then begins from address 0.
- start pulsed during HOLD and again during FIN → both ignored; bit sequence and done timing identical to the first scenario.
- RSTn=0 for 1 cycle mid-scan at bit 5 → all outputs zero the next cycle; no done pulse; a subsequent start behaves like the first scenario.
